fpu_cmp_sgnj_pipe: RTL

- Parametrised two-stage pipelined FP non-arithmetic unit: sign-injection (FSGNJ/FSGNJN/FSGNJX), FMIN/FMAX, FEQ/FLT/FLE and FCLASS.
- Exponent and fraction widths are generic; half precision is the default.
- Sits behind the FPU issue stage with valid/ready handshakes on both sides.
- Carries an opaque tag so the writeback stage can route results.

---
 rtl/fpu_cmp_sgnj_pipe.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_cmp_sgnj_pipe.sv
// Two-stage FP non-arithmetic unit: sign injection, min/max, compares and classify.
// Stage 1 registers operands plus operand decode; stage 2 registers the result.
module fpu_cmp_sgnj_pipe #(
    parameter int unsigned EXP_W   = 5,
    parameter int unsigned FRAC_W  = 10,
    parameter int unsigned TAG_W   = 5,
    localparam int unsigned FLOAT_W = 1 + EXP_W + FRAC_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [FLOAT_W-1:0] in_a,
    input  logic [FLOAT_W-1:0] in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLOAT_W-1:0] out_result,
    output logic               out_nv,
    output logic [TAG_W-1:0]   out_tag
);

    localparam logic [3:0] OP_SGNJ  = 4'd0;
    localparam logic [3:0] OP_SGNJN = 4'd1;
    localparam logic [3:0] OP_SGNJX = 4'd2;
    localparam logic [3:0] OP_MIN   = 4'd3;
    localparam logic [3:0] OP_MAX   = 4'd4;
    localparam logic [3:0] OP_EQ    = 4'd5;
    localparam logic [3:0] OP_LT    = 4'd6;
    localparam logic [3:0] OP_LE    = 4'd7;
    localparam logic [3:0] OP_CLASS = 4'd8;

    localparam logic [FLOAT_W-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // One-hot class: -inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN
    function automatic logic [9:0] classify(input logic [FLOAT_W-1:0] x);
        logic [9:0] cls;
        logic       sign, exp_ones, exp_zero, frac_zero, qbit, normal;
        sign      = x[FLOAT_W-1];
        exp_ones  = &x[FLOAT_W-2:FRAC_W];
        exp_zero  = ~|x[FLOAT_W-2:FRAC_W];
        frac_zero = ~|x[FRAC_W-1:0];
        qbit      = x[FRAC_W-1];
        normal    = !exp_ones && !exp_zero;
        cls    = '0;
        cls[0] =  sign && exp_ones && frac_zero;
        cls[1] =  sign && normal;
        cls[2] =  sign && exp_zero && !frac_zero;
        cls[3] =  sign && exp_zero && frac_zero;
        cls[4] = !sign && exp_zero && frac_zero;
        cls[5] = !sign && exp_zero && !frac_zero;
        cls[6] = !sign && normal;
        cls[7] = !sign && exp_ones && frac_zero;
        cls[8] =  exp_ones && !frac_zero && !qbit;
        cls[9] =  exp_ones && qbit;
        return cls;
    endfunction

    logic               s1_valid_q, s2_valid_q;
    logic [3:0]         s1_op_q;
    logic [TAG_W-1:0]   s1_tag_q, out_tag_q;
    logic [FLOAT_W-1:0] s1_a_q, s1_b_q, out_result_q, res_d;
    logic [9:0]         s1_acls_q, acls_d;
    logic               s1_bnan_q, s1_bsnan_q, s1_bzero_q;
    logic               bnan_d, bsnan_d, bzero_d;
    logic               out_nv_q, nv_d;
    logic               s1_en, s2_en;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    assign acls_d  = classify(in_a);
    assign bnan_d  = (&in_b[FLOAT_W-2:FRAC_W]) && (|in_b[FRAC_W-1:0]);
    assign bsnan_d = bnan_d && !in_b[FRAC_W-1];
    assign bzero_d = ~|in_b[FLOAT_W-2:0];

    // Pipeline registers; flush wins over every transfer
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_tag_q     <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_acls_q    <= '0;
            s1_bnan_q    <= 1'b0;
            s1_bsnan_q   <= 1'b0;
            s1_bzero_q   <= 1'b0;
            out_result_q <= '0;
            out_nv_q     <= 1'b0;
            out_tag_q    <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid;
            end
            if (s1_en && in_valid) begin
                s1_op_q    <= in_op;
                s1_tag_q   <= in_tag;
                s1_a_q     <= in_a;
                s1_b_q     <= in_b;
                s1_acls_q  <= acls_d;
                s1_bnan_q  <= bnan_d;
                s1_bsnan_q <= bsnan_d;
                s1_bzero_q <= bzero_d;
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_en && s1_valid_q) begin
                out_result_q <= res_d;
                out_nv_q     <= nv_d;
                out_tag_q    <= s1_tag_q;
            end
        end
    end

    logic a_sign, b_sign, a_nan, a_snan, a_zero, any_nan, any_snan, both_zero;
    logic a_lt_b, a_eq_b;

    assign a_sign    = s1_a_q[FLOAT_W-1];
    assign b_sign    = s1_b_q[FLOAT_W-1];
    assign a_nan     = s1_acls_q[8] || s1_acls_q[9];
    assign a_snan    = s1_acls_q[8];
    assign a_zero    = s1_acls_q[3] || s1_acls_q[4];
    assign any_nan   = a_nan || s1_bnan_q;
    assign any_snan  = a_snan || s1_bsnan_q;
    assign both_zero = a_zero && s1_bzero_q;
    assign a_eq_b    = (s1_a_q == s1_b_q);

    // Sign-magnitude ordering; -0 sorts below +0 here, compares mask that out
    always_comb begin
        a_lt_b = 1'b0;
        if (a_sign != b_sign) begin
            a_lt_b = a_sign;
        end else if (!a_sign) begin
            a_lt_b = s1_a_q[FLOAT_W-2:0] < s1_b_q[FLOAT_W-2:0];
        end else begin
            a_lt_b = s1_a_q[FLOAT_W-2:0] > s1_b_q[FLOAT_W-2:0];
        end
    end

    always_comb begin
        res_d = '0;
        nv_d  = 1'b0;
        case (s1_op_q)
            OP_SGNJ:  res_d = {b_sign, s1_a_q[FLOAT_W-2:0]};
            OP_SGNJN: res_d = {!b_sign, s1_a_q[FLOAT_W-2:0]};
            OP_SGNJX: res_d = {a_sign ^ b_sign, s1_a_q[FLOAT_W-2:0]};
            OP_MIN, OP_MAX: begin
                nv_d = any_snan;
                if (a_nan && s1_bnan_q) begin
                    res_d = CANON_NAN;
                end else if (a_nan) begin
                    res_d = s1_b_q;
                end else if (s1_bnan_q) begin
                    res_d = s1_a_q;
                end else if (s1_op_q == OP_MIN) begin
                    res_d = a_lt_b ? s1_a_q : s1_b_q;
                end else begin
                    res_d = a_lt_b ? s1_b_q : s1_a_q;
                end
            end
            OP_EQ: begin
                nv_d  = any_snan;
                res_d = FLOAT_W'(!any_nan && (a_eq_b || both_zero));
            end
            OP_LT: begin
                nv_d  = any_nan;
                res_d = FLOAT_W'(!any_nan && !both_zero && a_lt_b);
            end
            OP_LE: begin
                nv_d  = any_nan;
                res_d = FLOAT_W'(!any_nan && (both_zero || a_eq_b || a_lt_b));
            end
            OP_CLASS: res_d = FLOAT_W'(s1_acls_q);
            default: begin
                res_d = CANON_NAN;
                nv_d  = 1'b1;
            end
        endcase
    end

    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_nv     = out_nv_q;
    assign out_tag    = out_tag_q;

endmodule
